// File: rtl/cla_operand_gen.sv
// Operand source for the CLA self-test: four carry-chain corner vectors, then
// per-lane Galois LFSR vectors, presented through a fully registered valid/ready port.
module cla_operand_gen #(
  parameter int unsigned w      = 128,
  parameter logic [31:0] SEED_A = 32'h1,
  parameter logic [31:0] SEED_B = 32'h2,
  parameter int unsigned NVEC   = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [w-1:0] out_a,
  output logic [w-1:0] out_b,
  output logic         out_cin,
  output logic [31:0]  out_idx,
  output logic         done
);
  localparam int unsigned LANES    = w / 32;
  localparam logic [31:0] LAST_IDX = 32'(NVEC - 1);
  localparam logic [31:0] POLY     = 32'h80200003;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Lane k seed is base ^ (k << shift); a zero result would lock the LFSR, so use 1.
  function automatic logic [w-1:0] seed_vec(input logic [31:0] base, input int unsigned shift);
    logic [w-1:0] v;
    logic [31:0]  s;
    v = '0;
    for (int k = 0; k < LANES; k++) begin
      s = base ^ (32'(k) << shift);
      v[32*k +: 32] = (s == 32'h0) ? 32'h1 : s;
    end
    return v;
  endfunction

  function automatic logic [w-1:0] step_vec(input logic [w-1:0] v);
    logic [w-1:0] r;
    logic [31:0]  s;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      s = v[32*k +: 32];
      r[32*k +: 32] = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    end
    return r;
  endfunction

  localparam logic [w-1:0] SEED_VA = seed_vec(SEED_A, 0);
  localparam logic [w-1:0] SEED_VB = seed_vec(SEED_B, 8);

  state_t       state;
  logic [w-1:0] lfsr_a, lfsr_b, a_nxt, b_nxt, load_a, load_b;
  logic [31:0]  vec_idx;
  logic         cur_rand, wrapped, xfer, last_xfer, load, load_rand, load_cin;

  // The LFSRs hold the next random vector; they step only when a random vector leaves.
  always_comb begin
    xfer      = out_valid & out_ready;
    last_xfer = xfer && (NVEC != 0) && (out_idx == LAST_IDX);
    load      = en && ((state == IDLE) || (state == RUN && xfer && !last_xfer));
    a_nxt     = (xfer && cur_rand) ? step_vec(lfsr_a) : lfsr_a;
    b_nxt     = (xfer && cur_rand) ? step_vec(lfsr_b) : lfsr_b;
    load_rand = wrapped || (vec_idx > 32'd3);
    load_a    = a_nxt;
    load_b    = b_nxt;
    load_cin  = a_nxt[0] ^ b_nxt[0];
    if (!load_rand) begin
      case (vec_idx[1:0])
        2'd0: begin load_a = '0; load_b = '0; load_cin = 1'b0; end
        2'd1: begin load_a = '1; load_b = '0; load_cin = 1'b1; end
        2'd2: begin load_a = '1; load_b = '1; load_cin = 1'b1; end
        default: begin
          load_a   = {LANES{32'h55555555}};
          load_b   = {LANES{32'hAAAAAAAA}};
          load_cin = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_cin   <= 1'b0;
      out_idx   <= '0;
      done      <= 1'b0;
      lfsr_a    <= SEED_VA;
      lfsr_b    <= SEED_VB;
      vec_idx   <= '0;
      cur_rand  <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      lfsr_a <= a_nxt;
      lfsr_b <= b_nxt;
      case (state)
        IDLE: if (en) state <= RUN;
        RUN: begin
          if (last_xfer) begin
            state     <= DONE;
            out_valid <= 1'b0;
            done      <= 1'b1;
          end else if (xfer && !en) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
      // Corners appear only on the first pass; once the index wraps they never return.
      if (load) begin
        out_valid <= 1'b1;
        out_a     <= load_a;
        out_b     <= load_b;
        out_cin   <= load_cin;
        out_idx   <= vec_idx;
        cur_rand  <= load_rand;
        vec_idx   <= vec_idx + 32'd1;
        if (vec_idx == 32'hFFFFFFFF) wrapped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cla_operand_gen.sv
// Scoreboard bench: a behavioural model fills expected-vector queues, and every
// transfer seen on either instance is popped and compared.
module tb_cla_operand_gen;
  localparam int W     = 128;
  localparam int LANES = W / 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [31:0]  idx;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  logic en1, rdy1, v1, cin1, done1;
  logic en2, rdy2, v2, cin2, done2;
  logic [W-1:0] a1, b1, a2, b2;
  logic [31:0] idx1, idx2;

  vec_t q1[$];
  vec_t q2[$];
  int vectors = 0;
  int miscompares = 0;
  int xfer1 = 0;
  int xfer2 = 0;
  bit ok;

  always #5 clk = ~clk;

  cla_operand_gen #(.w(W), .SEED_A(32'hACE1), .SEED_B(32'hBEEF), .NVEC(0)) u1 (
    .clk(clk), .rstn(rstn), .en(en1), .out_ready(rdy1), .out_valid(v1),
    .out_a(a1), .out_b(b1), .out_cin(cin1), .out_idx(idx1), .done(done1)
  );

  cla_operand_gen #(.w(W), .SEED_A(32'h1), .SEED_B(32'h2), .NVEC(10)) u2 (
    .clk(clk), .rstn(rstn), .en(en2), .out_ready(rdy2), .out_valid(v2),
    .out_a(a2), .out_b(b2), .out_cin(cin2), .out_idx(idx2), .done(done2)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  task automatic build_stream(input bit which, input logic [31:0] sa, input logic [31:0] sb,
                              input int n);
    logic [31:0] la[LANES];
    logic [31:0] lb[LANES];
    vec_t v;
    for (int k = 0; k < LANES; k++) begin
      la[k] = sa ^ 32'(k);
      lb[k] = sb ^ (32'(k) << 8);
      if (la[k] == 32'h0) la[k] = 32'h1;
      if (lb[k] == 32'h0) lb[k] = 32'h1;
    end
    for (int i = 0; i < n; i++) begin
      v.idx = 32'(i);
      case (i)
        0: begin v.a = '0; v.b = '0; v.cin = 1'b0; end
        1: begin v.a = '1; v.b = '0; v.cin = 1'b1; end
        2: begin v.a = '1; v.b = '1; v.cin = 1'b1; end
        3: begin v.a = {LANES{32'h55555555}}; v.b = {LANES{32'hAAAAAAAA}}; v.cin = 1'b1; end
        default: begin
          for (int k = 0; k < LANES; k++) begin
            v.a[32*k +: 32] = la[k];
            v.b[32*k +: 32] = lb[k];
          end
          v.cin = la[0][0] ^ lb[0][0];
          for (int k = 0; k < LANES; k++) begin
            la[k] = lfsr_step(la[k]);
            lb[k] = lfsr_step(lb[k]);
          end
        end
      endcase
      if (which) q2.push_back(v);
      else q1.push_back(v);
    end
  endtask

  task automatic monitor();
    vec_t e;
    if (rstn && v1 && rdy1) begin
      check("u1_queue_has_entry", 128'(q1.size() != 0), 128'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("u1_idx", 128'(idx1), 128'(e.idx));
        check("u1_a", a1, e.a);
        check("u1_b", b1, e.b);
        check("u1_cin", 128'(cin1), 128'(e.cin));
      end
      xfer1++;
    end
    if (rstn && v2 && rdy2) begin
      check("u2_queue_has_entry", 128'(q2.size() != 0), 128'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        check("u2_idx", 128'(idx2), 128'(e.idx));
        check("u2_a", a2, e.a);
        check("u2_b", b2, e.b);
        check("u2_cin", 128'(cin2), 128'(e.cin));
      end
      xfer2++;
    end
  endtask

  // Outputs are sampled on the falling edge; inputs change just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus_wait_u1_idx(input logic [31:0] target, input string tag);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      cycle();
      if (v1 === 1'b1 && idx1 === target) ok = 1'b1;
    end
    check(tag, 128'(ok), 128'd1);
  endtask

  initial begin
    rstn = 1'b1; en1 = 1'b0; rdy1 = 1'b0; en2 = 1'b0; rdy2 = 1'b0;
    #1 rstn = 1'b0;
    #2;
    check("reset_valid", 128'(v1), 128'd0);
    check("reset_a", a1, '0);
    check("reset_b", b1, '0);
    check("reset_cin", 128'(cin1), 128'd0);
    check("reset_idx", 128'(idx1), 128'd0);
    check("reset_done", 128'(done1), 128'd0);
    check("reset_done_u2", 128'(done2), 128'd0);
    repeat (2) cycle();

    // Finite run: exactly ten transfers, then DONE regardless of en.
    build_stream(1'b1, 32'h1, 32'h2, 10);
    en2 = 1'b1; rdy2 = 1'b1; rstn = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cycle();
      if (done2 === 1'b1) ok = 1'b1;
    end
    check("fin_done_reached", 128'(ok), 128'd1);
    check("fin_xfer_count", 128'(xfer2), 128'd10);
    check("fin_valid_low", 128'(v2), 128'd0);
    check("fin_queue_drained", 128'(q2.size()), 128'd0);
    for (int i = 0; i < 4; i++) begin
      en2 = ~en2;
      cycle();
      check("fin_after_valid", 128'(v2), 128'd0);
      check("fin_after_done", 128'(done2), 128'd1);
    end
    en2 = 1'b0;

    // Pause after idx 6, then resume into idx 7.
    build_stream(1'b0, 32'hACE1, 32'hBEEF, 40);
    en1 = 1'b1; rdy1 = 1'b1;
    applyStimulus_wait_u1_idx(32'd6, "pause_reach_idx6");
    en1 = 1'b0;
    cycle();
    repeat (3) begin
      check("pause_valid_low", 128'(v1), 128'd0);
      cycle();
    end
    en1 = 1'b1;
    cycle();
    check("resume_valid", 128'(v1), 128'd1);
    check("resume_idx", 128'(idx1), 128'd7);

    // Backpressure: five stalled cycles hold the presented vector.
    applyStimulus_wait_u1_idx(32'd12, "bp_reach_idx12");
    rdy1 = 1'b0;
    repeat (5) begin
      cycle();
      check("bp_valid", 128'(v1), 128'd1);
      check("bp_idx", 128'(idx1), 128'd12);
      check("bp_a", a1, q1[0].a);
      check("bp_b", b1, q1[0].b);
    end
    rdy1 = 1'b1;

    // Reset mid-stream drops the vector immediately; the restart replays the corners.
    applyStimulus_wait_u1_idx(32'd20, "rst_reach_idx20");
    #2 rstn = 1'b0;
    #1;
    check("midrst_valid", 128'(v1), 128'd0);
    check("midrst_a", a1, '0);
    check("midrst_b", b1, '0);
    check("midrst_cin", 128'(cin1), 128'd0);
    check("midrst_idx", 128'(idx1), 128'd0);
    check("midrst_done", 128'(done1), 128'd0);
    q1.delete();
    build_stream(1'b0, 32'hACE1, 32'hBEEF, 10010);
    xfer1 = 0;
    cycle();
    rstn = 1'b1;

    ok = 1'b0;
    for (int i = 0; i < 40000 && !ok; i++) begin
      rdy1 = 1'($urandom_range(0, 1));
      cycle();
      if (xfer1 >= 10004) ok = 1'b1;
    end
    check("random_run_complete", 128'(ok), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cla_operand_gen.md
# cla_operand_gen

Pipelined operand source for the CLA self-test datapath. It sits directly upstream of the pipelined adder in the checker, on the same MMCM-derived clock and internal reset. It emits a deterministic stream of (A, B, carry-in) vectors: four fixed carry-chain corner cases, then pseudo-random vectors from per-lane LFSRs. The downstream checker can regenerate the identical stream from the same seeds to compute expected sums.

## Interface
- `w`, 128: operand width in bits. Must be a multiple of 32 and at least 32.
- `SEED_A`, 32'h1, base seed for the A lanes. Must be nonzero.
- `SEED_B`, 32'h2, base seed for the B lanes. Must be nonzero.
- `NVEC`, 0: number of vectors to emit before stopping. 0 means run continuously.

- `clk`  in  1  single clock for the block.
- `rstn`  in  1  reset, asynchronous and active-low.
- `en`  in  1  run enable, level-sensitive.
- `out_ready`  in  1  downstream accepts the current vector.
- `out_valid`  out  1  the vector on `out_a`/`out_b`/`out_cin`/`out_idx` is valid.
- `out_a`  out  w  operand A.
- `out_b`  out  w  operand B.
- `out_cin`  out  1  carry-in.
- `out_idx`  out  32  sequence number of the presented vector.
- `done`  out  1  high when all `NVEC` vectors have been transferred.

## Operation
- Transfer: a vector transfers in any cycle where `out_valid` and `out_ready` are both 1. While `out_valid`=1 and `out_ready`=0, all outputs hold stable.
- FSM states:
  - IDLE, the reset state, with `out_valid`=0. When `en`=1, it loads vector `idx`=0 and moves to RUN.
  - RUN with `en`=1: after each transfer, it loads the next vector and keeps `out_valid`=1.
  - RUN with `en`=0: after the pending vector transfers, it moves to IDLE. A vector already presented is never retracted.
  - RUN with `NVEC`≠0: the transfer with `idx`=`NVEC`-1 moves the FSM to DONE.
  - DONE: `out_valid`=0 and `done`=1. It stays there until `rstn` is asserted, ignoring `en`.
- Corner vectors, used for `idx` 0 to 3 and only on the first pass after reset:
  - idx 0: A=0, B=0, cin=0.
  - idx 1: A=all ones, B=0, cin=1. This gives a full carry ripple.
  - idx 2: A=all ones, B=all ones, cin=1.
  - idx 3: A=0x55…55, B=0xAA…AA, cin=1.
- Random vectors, used for `idx` ≥ 4:
  - Lanes: A and B are each built from w/32 lanes of 32-bit Galois LFSRs. Lane k occupies bits [32k+31:32k].
  - Lane seeds: lane k of A is seeded with `SEED_A`^k. Lane k of B is seeded with `SEED_B`^(k<<8). A lane whose seed works out to zero is seeded with 32'h1 instead.
  - LFSR step: if s[0]=1, s ← (s>>1) ^ 32'h80200003; otherwise s ← s>>1.
  - The presented A/B equal the current LFSR states.
  - Carry-in: `out_cin` = A lane0 bit 0 XOR B lane0 bit 0.
  - Advance: all lanes step exactly once per transfer of a random vector. Corner vectors do not step the LFSRs. The first random vector therefore equals the seeds.
- `out_idx`: increments by 1 per transfer. It wraps from 2^32−1 to 0. After a wrap, vectors stay random; corner vectors are not replayed.
- `en` toggling: pausing and resuming with `en` continues the sequence. It does not restart it.

## Timing
- Reset values: `out_valid`=0, `out_a`=0, `out_b`=0, `out_cin`=0, `out_idx`=0, `done`=0. The FSM is in IDLE and the LFSRs hold their seeds.
- Reset response: assertion of `rstn` takes effect immediately, without waiting for a clock. This applies mid-stream too: the current vector is dropped with no partial transfer.
- Start latency: `en` sampled high in IDLE at edge N gives `out_valid`=1 after edge N, with idx 0 presented.
- Throughput: one vector per cycle while `out_ready`=1 and `en`=1.
- Next vector: after a transfer at edge N, the next vector is visible after the same edge N.
- Stop: when `en` is low at a transfer edge, `out_valid`=0 from that edge onward.
- Done: `done` rises at the edge of the final transfer, in the same cycle that `out_valid` falls.
- Timing closure: all outputs are registered, with no combinational path from `out_ready` to the outputs. The block must close timing at the 330 MHz internal clock with w=128.

## Test plan
- Reset and start: hold `rstn`=0, then release with `en`=1 and `out_ready`=1. Required: idx 0–3 match the four corner vectors exactly, and idx 4 has A lane k = 32'h1^k.
- Backpressure: hold `out_ready`=0 for 5 cycles mid-stream. Required: outputs stay constant, `out_idx` does not advance, and the next vector is the correct successor.
- Finite run with `NVEC`=10: required is exactly 10 transfers with idx 0–9, then `done`=1 and `out_valid`=0. Toggling `en` afterwards must have no effect.
- Pause and resume: drop `en` for 3 cycles after idx 6 transfers. Required: `out_valid`=0 during the pause, and on resume idx 7 equals the value a reference LFSR model gives for idx 7.
- Reset mid-stream: assert `rstn` at idx 20 while `out_valid`=1. Required: all outputs go to their reset values immediately, and the restart replays the corners from idx 0.
- LFSR model check: over 10,000 random vectors with `out_ready` randomized, `out_a`/`out_b`/`out_cin` must match a behavioral LFSR model bit-exactly, using w=128 and seeds 32'hACE1 and 32'hBEEF.
